snitch_ptw_arbiter: RTL and testbench



---
 rtl/snitch_ptw_arbiter.sv | 128 ++++++++++++
 tb/tb_snitch_ptw_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_ptw_arbiter.sv
// Round-robin arbiter sharing one page table walker among several translation
// requesters, with optional broadcast of a completed walk to matching waiters.

package snitch_ptw_arbiter_pkg;
  // Field-bearing default so the top elaborates stand-alone; integrators pass their own va_t.
  typedef struct packed {
    logic [9:0] vpn1;
    logic [9:0] vpn0;
  } sv32_va_t;
endpackage

module snitch_ptw_arbiter #(
  parameter int unsigned NrReq       = 2,
  parameter int unsigned PPNSize     = 22,
  parameter type         va_t        = snitch_ptw_arbiter_pkg::sv32_va_t,
  parameter type         l0_pte_t    = logic,
  parameter bit          EnableMerge = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrReq-1:0]   req_valid_i,
  output logic [NrReq-1:0]   req_ready_o,
  input  va_t                req_va_i  [NrReq],
  input  logic [PPNSize-1:0] req_ppn_i [NrReq],
  output l0_pte_t            req_pte_o,
  output logic               req_is_4mega_o,
  output logic               ptw_valid_o,
  input  logic               ptw_ready_i,
  output va_t                ptw_va_o,
  output logic [PPNSize-1:0] ptw_ppn_o,
  input  l0_pte_t            ptw_pte_i,
  input  logic               ptw_is_4mega_i
);

  localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWalk = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] winner;
  logic            any_req;
  logic            walk_done;
  int unsigned     cand;

  // First valid requester found scanning upward from rr_q, wrapping at NrReq.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < NrReq; i++) begin
      cand = (32'(rr_q) + i) % NrReq;
      if (!any_req && req_valid_i[IdxW'(cand)]) begin
        any_req = 1'b1;
        winner  = IdxW'(cand);
      end
    end
  end

  assign walk_done = (state_q == StWalk) && ptw_ready_i && !rst_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StWalk;
          grant_d = winner;
        end
      end
      StWalk: begin
        if (ptw_ready_i) begin
          state_d = StIdle;
          rr_d    = IdxW'((32'(grant_q) + 1) % NrReq);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, even before the state register clears.
  assign ptw_valid_o    = (state_q == StWalk) && !rst_i;
  assign ptw_va_o       = req_va_i[grant_q];
  assign ptw_ppn_o      = req_ppn_i[grant_q];
  assign req_pte_o      = ptw_pte_i;
  assign req_is_4mega_o = ptw_is_4mega_i;

  // A super-page result covers every vpn0, so only vpn1 and the root PPN must agree then.
  always_comb begin
    req_ready_o = '0;
    if (walk_done) begin
      req_ready_o[grant_q] = 1'b1;
      if (EnableMerge) begin
        for (int unsigned j = 0; j < NrReq; j++) begin
          if (IdxW'(j) != grant_q && req_valid_i[IdxW'(j)] &&
              req_ppn_i[j] == ptw_ppn_o &&
              req_va_i[j].vpn1 == ptw_va_o.vpn1 &&
              (ptw_is_4mega_i || req_va_i[j].vpn0 == ptw_va_o.vpn0)) begin
            req_ready_o[IdxW'(j)] = 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NrReq; g++) begin : gen_hold_check
    assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[g] && !req_ready_o[g]) |=>
      (req_valid_i[g] && $stable(req_va_i[g]) && $stable(req_ppn_i[g])));
  end

endmodule

// File: tb/tb_snitch_ptw_arbiter.sv
// Bench for snitch_ptw_arbiter: directed scenarios on a 2-requester merging instance,
// then random traffic on it and on a 3-requester non-merging instance against a model.

module tb_snitch_ptw_arbiter;
  import snitch_ptw_arbiter_pkg::*;

  typedef logic [31:0] pte_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Requester/walker stimulus, index 0 = merging DUT, index 1 = non-merging DUT
  sv32_va_t    m_va  [2][3];
  logic [21:0] m_ppn [2][3];
  logic        m_val [2][3];
  logic        m_prdy [2];
  pte_t        m_pte  [2];
  logic        m_4m   [2];

  sv32_va_t    va_a [2];
  logic [21:0] ppn_a [2];
  sv32_va_t    va_b [3];
  logic [21:0] ppn_b [3];
  logic [1:0]  val_a;
  logic [2:0]  val_b;

  logic [1:0]  rdy_a;
  logic [2:0]  rdy_b;
  logic        pv_a, pv_b, m4_a, m4_b;
  sv32_va_t    pva_a, pva_b;
  logic [21:0] pppn_a, pppn_b;
  pte_t        pte_a, pte_b;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      va_a[i]  = m_va[0][i];
      ppn_a[i] = m_ppn[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      va_b[i]  = m_va[1][i];
      ppn_b[i] = m_ppn[1][i];
    end
    val_a = {m_val[0][1], m_val[0][0]};
    val_b = {m_val[1][2], m_val[1][1], m_val[1][0]};
  end

  snitch_ptw_arbiter #(
    .NrReq(2), .PPNSize(22), .va_t(sv32_va_t), .l0_pte_t(pte_t), .EnableMerge(1'b1)
  ) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(val_a), .req_ready_o(rdy_a), .req_va_i(va_a), .req_ppn_i(ppn_a),
    .req_pte_o(pte_a), .req_is_4mega_o(m4_a),
    .ptw_valid_o(pv_a), .ptw_ready_i(m_prdy[0]), .ptw_va_o(pva_a), .ptw_ppn_o(pppn_a),
    .ptw_pte_i(m_pte[0]), .ptw_is_4mega_i(m_4m[0])
  );

  snitch_ptw_arbiter #(
    .NrReq(3), .PPNSize(22), .va_t(sv32_va_t), .l0_pte_t(pte_t), .EnableMerge(1'b0)
  ) u_nm (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(val_b), .req_ready_o(rdy_b), .req_va_i(va_b), .req_ppn_i(ppn_b),
    .req_pte_o(pte_b), .req_is_4mega_o(m4_b),
    .ptw_valid_o(pv_b), .ptw_ready_i(m_prdy[1]), .ptw_va_o(pva_b), .ptw_ppn_o(pppn_b),
    .ptw_pte_i(m_pte[1]), .ptw_is_4mega_i(m_4m[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; inputs are then driven at the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int d, input int i, input logic [9:0] v1,
                         input logic [9:0] v0, input logic [21:0] p);
    m_va[d][i].vpn1 = v1;
    m_va[d][i].vpn0 = v0;
    m_ppn[d][i]     = p;
  endtask

  task automatic set_val_a(input logic [1:0] v);
    m_val[0][0] = v[0];
    m_val[0][1] = v[1];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 0, 10'h1, 10'h1, 22'h1);
    set_req(0, 1, 10'h2, 10'h2, 22'h2);
    set_val_a(2'b11);
    m_prdy[0] = 1'b1;
    #1;
    total++; if (pv_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_during got=%0b exp=0", pv_a); end
    total++; if (rdy_a !== 2'b00) begin bad++; $display("[TB] FAIL reset_ready_during got=%b exp=00", rdy_a); end
    step();
    rst = 1'b0;
    set_val_a(2'b00);
    m_prdy[0] = 1'b0;
    m_pte[0]  = 32'hDEAD_BEEF;
    m_4m[0]   = 1'b1;
    #1;
    total++; if (pv_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_after got=%0b exp=0", pv_a); end
    total++; if (rdy_a !== 2'b00) begin bad++; $display("[TB] FAIL reset_ready_after got=%b exp=00", rdy_a); end
    total++; if (pv_b !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_nm got=%0b exp=0", pv_b); end
    total++; if (pte_a !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL pte_passthru got=%h exp=deadbeef", pte_a); end
    total++; if (m4_a !== 1'b1) begin bad++; $display("[TB] FAIL 4mega_passthru got=%0b exp=1", m4_a); end
    m_4m[0] = 1'b0;
  endtask

  // Both requesters held: grants alternate 0,1,0,1 with one idle cycle between walks
  task automatic test_alternate();
    int g;
    logic [1:0] er;
    set_req(0, 0, 10'h010, 10'h001, 22'h100);
    set_req(0, 1, 10'h020, 10'h002, 22'h200);
    set_val_a(2'b11);
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      #1;
      total++; if (pv_a !== 1'b0) begin bad++; $display("[TB] FAIL alt_idle k=%0d got=%0b exp=0", k, pv_a); end
      step();
      for (int w = 1; w <= 3; w++) begin
        m_prdy[0] = (w == 3);
        #1;
        er = (w == 3) ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00;
        total++; if (pv_a !== 1'b1) begin bad++; $display("[TB] FAIL alt_valid k=%0d w=%0d got=%0b exp=1", k, w, pv_a); end
        total++; if (pva_a !== m_va[0][g]) begin bad++; $display("[TB] FAIL alt_va k=%0d got=%h exp=%h", k, pva_a, m_va[0][g]); end
        total++; if (rdy_a !== er) begin bad++; $display("[TB] FAIL alt_ready k=%0d w=%0d got=%b exp=%b", k, w, rdy_a, er); end
        step();
      end
      m_prdy[0] = 1'b0;
      if (k >= 2) m_val[0][g] = 1'b0;
    end
  endtask

  // Lone request: walk cycles 1-4, completion at cycle 4, idle at cycle 5
  task automatic test_single();
    set_req(0, 0, 10'h001, 10'h002, 22'h3ABCD);
    set_val_a(2'b01);
    #1;
    total++; if (pv_a !== 1'b0) begin bad++; $display("[TB] FAIL single_c0_valid got=%0b exp=0", pv_a); end
    step();
    for (int c = 1; c <= 4; c++) begin
      m_prdy[0] = (c == 4);
      m_pte[0]  = $urandom;
      m_4m[0]   = 1'($urandom % 2);
      #1;
      total++; if (pv_a !== 1'b1) begin bad++; $display("[TB] FAIL single_valid c=%0d got=%0b exp=1", c, pv_a); end
      total++; if (pppn_a !== 22'h3ABCD) begin bad++; $display("[TB] FAIL single_ppn c=%0d got=%h exp=3abcd", c, pppn_a); end
      total++; if (rdy_a !== ((c == 4) ? 2'b01 : 2'b00)) begin bad++; $display("[TB] FAIL single_ready c=%0d got=%b", c, rdy_a); end
      if (c == 4) begin
        total++; if (pte_a !== m_pte[0]) begin bad++; $display("[TB] FAIL single_pte got=%h exp=%h", pte_a, m_pte[0]); end
        total++; if (m4_a !== m_4m[0]) begin bad++; $display("[TB] FAIL single_4m got=%0b exp=%0b", m4_a, m_4m[0]); end
      end
      step();
    end
    m_prdy[0] = 1'b0;
    set_val_a(2'b00);
    #1;
    total++; if (pv_a !== 1'b0) begin bad++; $display("[TB] FAIL single_c5_idle got=%0b exp=0", pv_a); end
  endtask

  // One walk with completion on its first cycle; expected ready pattern and granted vpn0
  task automatic merge_walk(input string nm, input logic is4m, input logic [1:0] er,
                            input logic [9:0] ev0);
    #1;
    step();
    m_prdy[0] = 1'b1;
    m_4m[0]   = is4m;
    #1;
    total++; if (rdy_a !== er) begin bad++; $display("[TB] FAIL %s_ready got=%b exp=%b", nm, rdy_a, er); end
    total++; if (pva_a.vpn0 !== ev0) begin bad++; $display("[TB] FAIL %s_vpn0 got=%h exp=%h", nm, pva_a.vpn0, ev0); end
    step();
    m_prdy[0] = 1'b0;
    m_4m[0]   = 1'b0;
  endtask

  task automatic test_merge();
    // Identical translation: one walk retires both (rr=1, so requester 1 is granted)
    set_req(0, 0, 10'h012, 10'h005, 22'h155);
    set_req(0, 1, 10'h012, 10'h005, 22'h155);
    set_val_a(2'b11);
    merge_walk("merge_same", 1'b0, 2'b11, 10'h005);
    set_val_a(2'b00);
    // Different vpn0, 4 KiB result: requester 0 alone, then a second walk for 1
    set_req(0, 1, 10'h012, 10'h006, 22'h155);
    set_val_a(2'b11);
    merge_walk("merge_4k_first", 1'b0, 2'b01, 10'h005);
    m_val[0][0] = 1'b0;
    merge_walk("merge_4k_second", 1'b0, 2'b10, 10'h006);
    set_val_a(2'b00);
    // Different vpn0 but super-page result covers both
    set_val_a(2'b11);
    merge_walk("merge_4m", 1'b1, 2'b11, 10'h005);
    set_val_a(2'b00);
    // Root PPN differs: never merged even for a super page (rr=1, requester 1 first)
    set_req(0, 1, 10'h012, 10'h005, 22'h156);
    set_val_a(2'b11);
    merge_walk("merge_ppn_first", 1'b1, 2'b10, 10'h005);
    m_val[0][1] = 1'b0;
    merge_walk("merge_ppn_second", 1'b1, 2'b01, 10'h005);
    set_val_a(2'b00);
  endtask

  // rr=1 on entry; reset mid-walk must abandon it and restart round-robin at 0
  task automatic test_reset_mid_walk();
    set_req(0, 0, 10'h030, 10'h001, 22'h011);
    set_req(0, 1, 10'h031, 10'h002, 22'h022);
    set_val_a(2'b11);
    #1;
    step();
    #1;
    total++; if (pva_a !== m_va[0][1]) begin bad++; $display("[TB] FAIL rst_pre_grant got=%h exp=%h", pva_a, m_va[0][1]); end
    step();
    rst = 1'b1;
    #1;
    total++; if (pv_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_c2_valid got=%0b exp=0", pv_a); end
    step();
    rst = 1'b0;
    m_prdy[0] = 1'b1;
    #1;
    total++; if (pv_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_c3_valid got=%0b exp=0", pv_a); end
    total++; if (rdy_a !== 2'b00) begin bad++; $display("[TB] FAIL rst_c3_ready got=%b exp=00", rdy_a); end
    step();
    m_prdy[0] = 1'b0;
    #1;
    total++; if (pv_a !== 1'b1) begin bad++; $display("[TB] FAIL rst_c4_valid got=%0b exp=1", pv_a); end
    total++; if (pva_a !== m_va[0][0]) begin bad++; $display("[TB] FAIL rst_rr_restart got=%h exp=%h", pva_a, m_va[0][0]); end
    step();
    m_prdy[0] = 1'b1;
    #1;
    total++; if (rdy_a !== 2'b01) begin bad++; $display("[TB] FAIL rst_done0 got=%b exp=01", rdy_a); end
    step();
    m_prdy[0]   = 1'b0;
    m_val[0][0] = 1'b0;
    merge_walk("rst_done1", 1'b0, 2'b10, 10'h002);
    set_val_a(2'b00);
  endtask

  task automatic test_idle_ready();
    set_val_a(2'b00);
    m_prdy[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (rdy_a !== 2'b00) begin bad++; $display("[TB] FAIL idle_ready c=%0d got=%b exp=00", c, rdy_a); end
      total++; if (pv_a !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid c=%0d got=%0b exp=0", c, pv_a); end
      step();
    end
    m_prdy[0] = 1'b0;
    set_req(0, 0, 10'h040, 10'h004, 22'h044);
    set_val_a(2'b01);
    #1;
    total++; if (pv_a !== 1'b0) begin bad++; $display("[TB] FAIL idle_latency0 got=%0b exp=0", pv_a); end
    step();
    #1;
    total++; if (pv_a !== 1'b1) begin bad++; $display("[TB] FAIL idle_latency1 got=%0b exp=1", pv_a); end
    step();
    m_prdy[0] = 1'b1;
    #1;
    total++; if (rdy_a !== 2'b01) begin bad++; $display("[TB] FAIL idle_done got=%b exp=01", rdy_a); end
    step();
    m_prdy[0] = 1'b0;
    set_val_a(2'b00);
  endtask

  // Random traffic on both instances against a transaction-level model
  task automatic test_random();
    bit          busy [2];
    int          who [2];
    int          rr [2];
    bit          retired [2][3];
    int          n, j;
    bit          found, merge;
    logic [2:0]  exp_rdy, o_rdy;
    logic        o_pv, o_4m;
    sv32_va_t    o_va;
    logic [21:0] o_ppn;
    pte_t        o_pte;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin m_val[d][i] = 1'b0; retired[d][i] = 1'b0; end
      busy[d] = 1'b0; who[d] = 0; rr[d] = 0;
      m_prdy[d] = 1'b0;
    end
    step();
    rst = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        n = (d == 0) ? 2 : 3;
        for (int i = 0; i < n; i++) begin
          if (!m_val[d][i] || retired[d][i]) begin
            m_val[d][i] = ($urandom % 3) != 0;
            set_req(d, i, 10'($urandom % 2), 10'($urandom % 2), 22'($urandom % 2));
          end
        end
        m_prdy[d] = ($urandom % 3) == 0;
        m_pte[d]  = $urandom;
        m_4m[d]   = 1'($urandom % 2);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        n     = (d == 0) ? 2 : 3;
        merge = (d == 0);
        exp_rdy = 3'b000;
        if (busy[d] && m_prdy[d]) begin
          exp_rdy = exp_rdy | (3'b001 << who[d]);
          for (int k = 0; k < n; k++) begin
            if (merge && k != who[d] && m_val[d][k] && m_ppn[d][k] == m_ppn[d][who[d]] &&
                m_va[d][k].vpn1 == m_va[d][who[d]].vpn1 &&
                (m_4m[d] || m_va[d][k].vpn0 == m_va[d][who[d]].vpn0))
              exp_rdy = exp_rdy | (3'b001 << k);
          end
        end
        if (d == 0) begin
          o_pv = pv_a; o_rdy = {1'b0, rdy_a}; o_va = pva_a; o_ppn = pppn_a; o_pte = pte_a; o_4m = m4_a;
        end else begin
          o_pv = pv_b; o_rdy = rdy_b; o_va = pva_b; o_ppn = pppn_b; o_pte = pte_b; o_4m = m4_b;
        end
        total++; if (o_pv !== busy[d]) begin bad++; $display("[TB] FAIL rnd_valid d=%0d cyc=%0d got=%0b exp=%0b", d, cyc, o_pv, busy[d]); end
        total++; if (o_rdy !== exp_rdy) begin bad++; $display("[TB] FAIL rnd_ready d=%0d cyc=%0d got=%b exp=%b", d, cyc, o_rdy, exp_rdy); end
        total++; if (o_pte !== m_pte[d] || o_4m !== m_4m[d]) begin bad++; $display("[TB] FAIL rnd_passthru d=%0d cyc=%0d got=%h/%0b exp=%h/%0b", d, cyc, o_pte, o_4m, m_pte[d], m_4m[d]); end
        if (busy[d]) begin
          total++; if (o_va !== m_va[d][who[d]] || o_ppn !== m_ppn[d][who[d]]) begin bad++; $display("[TB] FAIL rnd_walk_req d=%0d cyc=%0d got=%h/%h exp=%h/%h", d, cyc, o_va, o_ppn, m_va[d][who[d]], m_ppn[d][who[d]]); end
        end
        for (int i = 0; i < n; i++) retired[d][i] = ((exp_rdy >> i) & 3'b001) != 3'b000;
        if (busy[d]) begin
          if (m_prdy[d]) begin
            busy[d] = 1'b0;
            rr[d]   = (who[d] + 1) % n;
          end
        end else begin
          found = 1'b0;
          for (int k = 0; k < n; k++) begin
            j = (rr[d] + k) % n;
            if (!found && m_val[d][j]) begin
              found = 1'b1; busy[d] = 1'b1; who[d] = j;
            end
          end
        end
      end
      step();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        m_val[d][i] = 1'b0;
        m_va[d][i]  = '0;
        m_ppn[d][i] = '0;
      end
      m_prdy[d] = 1'b0;
      m_pte[d]  = '0;
      m_4m[d]   = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_alternate();
    test_single();
    test_merge();
    test_reset_mid_walk();
    test_idle_ready();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
